// File: rtl/ahb_bus_arbiter.sv
// Two-master (CPU / DMA) AHB-lite bus arbiter with a bounded hold time.
// Ownership changes only at an IDLE address phase; HMaster_Data trails HMaster by one ready cycle.
module ahb_bus_arbiter #(
    parameter int MAX_HOLD     = 16,
    parameter bit DMA_PRIORITY = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       Cpu_Req,
    input  logic       Dma_Req,
    input  logic [1:0] Cpu_HTrans,
    input  logic [1:0] Dma_HTrans,
    input  logic       HReady,
    output logic       Cpu_Grant,
    output logic       Dma_Grant,
    output logic       HMaster,
    output logic       HMaster_Data
);
    localparam int            CW          = $clog2(MAX_HOLD + 1);
    localparam logic [CW-1:0] HOLD_LIMIT  = CW'(MAX_HOLD);
    localparam logic [1:0]    HTRANS_IDLE = 2'b00;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CPU_OWN,
        ST_DMA_OWN,
        ST_DRAIN
    } state_t;

    state_t        state_reg, state_next;
    logic [CW-1:0] hold_reg, hold_next;
    logic          hmaster_reg, hmaster_next;
    logic          hmaster_data_reg;
    logic          cpu_grant_reg, dma_grant_reg;

    // In OWN and DRAIN the registered HMaster is the current owner (X); Y is the other master.
    logic       owner, x_req, y_req, owner_idle, release_cond;
    logic [1:0] x_htrans;
    logic       pick_any, pick_owner, idle_winner;
    state_t     pick_state;

    assign owner        = hmaster_reg;
    assign x_req        = owner ? Dma_Req : Cpu_Req;
    assign y_req        = owner ? Cpu_Req : Dma_Req;
    assign x_htrans     = owner ? Dma_HTrans : Cpu_HTrans;
    assign owner_idle   = HReady && (x_htrans == HTRANS_IDLE);
    assign release_cond = !x_req || ((hold_reg == HOLD_LIMIT) && y_req);
    assign pick_any     = x_req || y_req;
    assign pick_owner   = y_req ? ~owner : owner;
    assign idle_winner  = (Cpu_Req && Dma_Req) ? DMA_PRIORITY : Dma_Req;

    always_comb begin
        state_next   = state_reg;
        hold_next    = hold_reg;
        hmaster_next = hmaster_reg;
        pick_state   = ST_IDLE;
        if (pick_any) begin
            pick_state = pick_owner ? ST_DMA_OWN : ST_CPU_OWN;
        end

        case (state_reg)
            ST_IDLE: begin
                if (Cpu_Req || Dma_Req) begin
                    state_next   = idle_winner ? ST_DMA_OWN : ST_CPU_OWN;
                    hmaster_next = idle_winner;
                    hold_next    = '0;
                end
            end
            ST_CPU_OWN, ST_DMA_OWN: begin
                if (release_cond) begin
                    if (owner_idle) begin
                        state_next = pick_state;
                        if (pick_any) begin
                            hmaster_next = pick_owner;
                            hold_next    = '0;
                        end
                    end else begin
                        state_next = ST_DRAIN;
                    end
                end else if (HReady && x_htrans[1] && y_req && (hold_reg != HOLD_LIMIT)) begin
                    hold_next = hold_reg + 1'b1;
                end
            end
            ST_DRAIN: begin
                // Wait out BUSY and stalled phases until the owner shows an IDLE address phase.
                if (owner_idle) begin
                    state_next = pick_state;
                    if (pick_any) begin
                        hmaster_next = pick_owner;
                        hold_next    = '0;
                    end
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg        <= ST_IDLE;
            hold_reg         <= '0;
            hmaster_reg      <= 1'b0;
            hmaster_data_reg <= 1'b0;
            cpu_grant_reg    <= 1'b0;
            dma_grant_reg    <= 1'b0;
        end else begin
            state_reg     <= state_next;
            hold_reg      <= hold_next;
            hmaster_reg   <= hmaster_next;
            cpu_grant_reg <= (state_next == ST_CPU_OWN);
            dma_grant_reg <= (state_next == ST_DMA_OWN);
            if (HReady) begin
                hmaster_data_reg <= hmaster_reg;
            end
        end
    end

    assign Cpu_Grant    = cpu_grant_reg;
    assign Dma_Grant    = dma_grant_reg;
    assign HMaster      = hmaster_reg;
    assign HMaster_Data = hmaster_data_reg;

endmodule

// File: tb/tb_ahb_bus_arbiter.sv
// Bench for ahb_bus_arbiter: two instances (MAX_HOLD=4/DMA priority, MAX_HOLD=16/CPU priority)
// driven by shared directed + random stimulus and compared each cycle with a rule-level model.
module tb_ahb_bus_arbiter;
    logic       clk = 1'b0;
    logic       rst;
    logic       cpu_req, dma_req, hready;
    logic [1:0] cpu_htrans, dma_htrans;
    logic [1:0] cpu_grant, dma_grant, hmaster, hmaster_data;

    int n_compared   = 0;
    int n_mismatched = 0;

    always #5 clk = ~clk;

    ahb_bus_arbiter #(.MAX_HOLD(4), .DMA_PRIORITY(1'b1)) dut_a (
        .clk(clk), .rst(rst), .Cpu_Req(cpu_req), .Dma_Req(dma_req),
        .Cpu_HTrans(cpu_htrans), .Dma_HTrans(dma_htrans), .HReady(hready),
        .Cpu_Grant(cpu_grant[0]), .Dma_Grant(dma_grant[0]),
        .HMaster(hmaster[0]), .HMaster_Data(hmaster_data[0])
    );

    ahb_bus_arbiter #(.MAX_HOLD(16), .DMA_PRIORITY(1'b0)) dut_b (
        .clk(clk), .rst(rst), .Cpu_Req(cpu_req), .Dma_Req(dma_req),
        .Cpu_HTrans(cpu_htrans), .Dma_HTrans(dma_htrans), .HReady(hready),
        .Cpu_Grant(cpu_grant[1]), .Dma_Grant(dma_grant[1]),
        .HMaster(hmaster[1]), .HMaster_Data(hmaster_data[1])
    );

    // Reference model: who holds the bus (-1 = nobody), whether a handover is pending,
    // beats counted against the waiting master, and the two owner selects.
    int max_hold [2] = '{4, 16};
    int prio     [2] = '{1, 0};
    int own_m    [2];
    bit pend_m   [2];
    int beats_m  [2];
    int hm_m     [2];
    int hmd_m    [2];
    int prev_cg  [2];
    int prev_dg  [2];

    task automatic check_eq(input string tag, input int got, input int exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic give_bus(input int m, input int who);
        own_m[m]   = who;
        pend_m[m]  = 1'b0;
        beats_m[m] = 0;
        hm_m[m]    = who;
    endtask

    task automatic model_step(input int m);
        int x, xreq, yreq, xt, win;
        if (rst) begin
            own_m[m] = -1; pend_m[m] = 1'b0; beats_m[m] = 0; hm_m[m] = 0; hmd_m[m] = 0;
            return;
        end
        if (hready) hmd_m[m] = hm_m[m];
        if (own_m[m] < 0) begin
            win = -1;
            if (cpu_req && dma_req) win = prio[m];
            else if (dma_req)       win = 1;
            else if (cpu_req)       win = 0;
            if (win >= 0) give_bus(m, win);
            return;
        end
        x    = own_m[m];
        xreq = (x == 1) ? int'(dma_req) : int'(cpu_req);
        yreq = (x == 1) ? int'(cpu_req) : int'(dma_req);
        xt   = (x == 1) ? int'(dma_htrans) : int'(cpu_htrans);
        if (pend_m[m] || !xreq || (beats_m[m] == max_hold[m] && yreq)) begin
            if (hready && xt == 0) begin
                if (yreq)      give_bus(m, 1 - x);
                else if (xreq) give_bus(m, x);
                else begin own_m[m] = -1; pend_m[m] = 1'b0; end
            end else begin
                pend_m[m] = 1'b1;
            end
        end else if (hready && xt >= 2 && yreq && beats_m[m] < max_hold[m]) begin
            beats_m[m]++;
        end
    endtask

    // One clock: update the model with the inputs seen at the edge, then compare 1 ns later.
    task automatic tick();
        int exp_cg, exp_dg;
        @(posedge clk);
        for (int m = 0; m < 2; m++) model_step(m);
        #1;
        for (int m = 0; m < 2; m++) begin
            exp_cg = (own_m[m] == 0 && !pend_m[m]) ? 1 : 0;
            exp_dg = (own_m[m] == 1 && !pend_m[m]) ? 1 : 0;
            check_eq($sformatf("cpu_grant[%0d]", m), int'(cpu_grant[m]), exp_cg);
            check_eq($sformatf("dma_grant[%0d]", m), int'(dma_grant[m]), exp_dg);
            check_eq($sformatf("hmaster[%0d]", m), int'(hmaster[m]), hm_m[m]);
            check_eq($sformatf("hmaster_data[%0d]", m), int'(hmaster_data[m]), hmd_m[m]);
            if (exp_cg != prev_cg[m] || exp_dg != prev_dg[m])
                $display("[%0t] inst%0d grant cpu=%0d dma=%0d hmaster=%0d", $time, m,
                         exp_cg, exp_dg, hm_m[m]);
            prev_cg[m] = exp_cg;
            prev_dg[m] = exp_dg;
        end
    endtask

    initial begin
        for (int m = 0; m < 2; m++) begin
            own_m[m] = -1; pend_m[m] = 1'b0; beats_m[m] = 0;
            hm_m[m] = 0; hmd_m[m] = 0; prev_cg[m] = 0; prev_dg[m] = 0;
        end
        rst = 1'b1; cpu_req = 1'b0; dma_req = 1'b0; hready = 1'b1;
        cpu_htrans = 2'b00; dma_htrans = 2'b00;

        // Reset, then a lone DMA request
        tick(); tick();
        check_eq("reset_outputs", int'({cpu_grant, dma_grant, hmaster, hmaster_data}), 0);
        rst = 1'b0;
        tick(); tick();
        dma_req = 1'b1;
        tick();
        check_eq("single_req_dma_grant", int'(dma_grant[0]), 1);
        check_eq("single_req_hmaster", int'(hmaster[0]), 1);
        tick();
        check_eq("single_req_hmaster_data", int'(hmaster_data[0]), 1);

        // Voluntary DMA release to IDLE, then simultaneous requests
        dma_req = 1'b0;
        tick(); tick();
        cpu_req = 1'b1; dma_req = 1'b1;
        tick();
        check_eq("simul_prio_dma", int'({cpu_grant[0], dma_grant[0]}), 1);
        check_eq("simul_prio_cpu", int'({cpu_grant[1], dma_grant[1]}), 2);

        // Hold limit on instance A: DMA bursts while the CPU waits
        for (int i = 0; i < 5; i++) begin
            dma_htrans = (i == 0) ? 2'b10 : 2'b11;
            tick();
            if (i == 3) check_eq("hold_grant_before_limit", int'(dma_grant[0]), 1);
        end
        check_eq("hold_grant_revoked", int'(dma_grant[0]), 0);
        dma_htrans = 2'b00;
        tick();
        check_eq("hold_cpu_granted", int'(cpu_grant[0]), 1);

        // CPU drops its request mid-burst, then HReady stalls in the drain
        dma_req = 1'b0; cpu_htrans = 2'b11; cpu_req = 1'b0;
        tick();
        hready = 1'b0; cpu_htrans = 2'b00;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq("stall_grants_low", int'({cpu_grant[0], dma_grant[0]}), 0);
            check_eq("stall_hmaster_held", int'(hmaster[0]), 0);
        end
        hready = 1'b1; dma_req = 1'b1;
        tick();
        check_eq("stall_exit_dma", int'(dma_grant[0]), 1);

        // DMA hands to CPU, then CPU voluntarily releases
        dma_req = 1'b0; cpu_req = 1'b1;
        tick();
        cpu_req = 1'b0;
        tick();
        check_eq("voluntary_idle_grants", int'({cpu_grant[0], dma_grant[0]}), 0);
        check_eq("voluntary_hmaster", int'(hmaster[0]), 0);

        // Reset while draining a DMA burst
        dma_req = 1'b1;
        tick();
        dma_htrans = 2'b11; dma_req = 1'b0;
        tick();
        check_eq("drain_hmaster_dma", int'(hmaster[0]), 1);
        rst = 1'b1;
        tick();
        check_eq("reset_in_drain", int'({cpu_grant, dma_grant, hmaster, hmaster_data}), 0);
        rst = 1'b0; dma_htrans = 2'b00;
        tick();

        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 7) == 0) cpu_req = ~cpu_req;
            if ($urandom_range(0, 7) == 0) dma_req = ~dma_req;
            cpu_htrans = 2'($urandom_range(0, 3));
            dma_htrans = 2'($urandom_range(0, 3));
            hready     = ($urandom_range(0, 3) != 0);
            rst        = ($urandom_range(0, 199) == 0);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end
endmodule
